spi_controller: RTL and testbench
=================================

# spi_controller

Write-only SPI initiator (mode 0, MSB first) that produces the 16-bit register-write frames the on-chip `spi_peripheral` receives. It accepts a 7-bit address and 8-bit data over a ready/request handshake and drives `sclk`, `ncs` and `copi`. It is used as a bench and loopback driver and as a bridge from internal logic onto the peripheral's `ui_in[0..2]` pins. Frame format is `{1'b1 (write), addr[6:0], data[7:0]}`; bit 15 is sent first.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period. Must be ≥ 2 so the peripheral's 2-FF synchronisers see every level.
- `CS_GAP`, default 4: clocks `ncs` stays high after a frame before `ready` returns. Must be ≥ 1.

- `clk` in 1: system clock, the same clock as the peripheral.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: request a frame; accepted on a rising `clk` edge where `req && ready`.
- `ready` out 1: high only in IDLE.
- `addr` in 7: register address, latched on accept.
- `wdata` in 8: register data, latched on accept.
- `busy` out 1: high from the cycle after accept until the return to IDLE.
- `done` out 1: one-cycle pulse, asserted in the same cycle `ncs` returns high.
- `sclk` out 1: SPI clock, idles low.
- `ncs` out 1: chip select, active low.
- `copi` out 1: serial data, controller to peripheral.

## Operation
- States: IDLE, LOW, HIGH, HOLD, GAP.
- All outputs are registered; `ready = (state == IDLE)`.
- **IDLE**
  - Outputs: `ncs=1`, `sclk=0`, `copi=0`, `busy=0`.
  - On accept: load the shift register with `{1, addr, wdata}`, set bit counter = 15, go to LOW.
  - Registered outputs after the accept edge: `ncs=0`, `copi=frame[15]`, `busy=1`.
- **LOW**: `sclk=0` for `CLK_DIV` cycles, then go to HIGH with `sclk=1`.
- **HIGH**: `sclk=1` for `CLK_DIV` cycles, then:
  - If bit counter ≠ 0: decrement it, shift left, put the next bit on `copi`, `sclk=0`, go to LOW.
  - If bit counter = 0: `sclk=0`, `copi=0`, go to HOLD.
- **HOLD**: `ncs` stays low for `CLK_DIV` cycles. Then `ncs=1`, `done=1` for one cycle, go to GAP.
- **GAP**: `CS_GAP` cycles with `ncs=1`, then IDLE and `ready=1`.
- Rules:
  - `copi` changes only in the cycle `sclk` falls (or `ncs` falls, for bit 15). It is therefore stable for `CLK_DIV` cycles on each side of every rising `sclk` edge.
  - `req` while not ready is ignored; there is no queueing.
  - `addr`/`wdata` changes after accept have no effect on the frame in flight.
  - `req` held high continuously produces back-to-back frames, each accepted in the first IDLE cycle.
  - Reset mid-frame: outputs return immediately to the reset values. The peripheral sees `ncs` rise with fewer than 16 bits and discards the frame. No further `sclk` edges occur until a new accept.
- Counters:
  - Phase counter is `$clog2(max(CLK_DIV, CS_GAP)+1)` bits.
  - Bit counter is 4 bits, counts down 15→0 and does not wrap.

## Timing
- Reset values: `ncs=1`, `sclk=0`, `copi=0`, `busy=0`, `done=0`, `ready=1`, state IDLE.
- Accept edge to `ncs` falling: 1 cycle (registered).
- `ncs` fall to first `sclk` rise: `CLK_DIV` cycles.
- SCLK period: `2·CLK_DIV`. There are exactly 16 rising edges per frame.
- Last `sclk` fall to `ncs` rise: `CLK_DIV` cycles.
- `ncs` low time: `33·CLK_DIV` cycles (132 at defaults).
- `ncs` rise to `ready`: `CS_GAP` cycles.
- Accept to next possible accept: `1 + 33·CLK_DIV + CS_GAP` cycles (137 at defaults).
- `done` rises in the same cycle as `ncs` rises.

## Test plan
- **Single write**: reset, then `addr=0x00`, `wdata=0xA5`, pulse `req`. Sampling `copi` on each `sclk` rise gives `1000_0000_1010_0101`. There are exactly 16 rises, `ncs` is low for 132 cycles, `done` pulses once, and `ready` returns 4 cycles after `done`.
- **Loopback**: connect to `spi_peripheral` (`sclk`→`ui_in[0]`, `ncs`→`ui_in[1]`, `copi`→`ui_in[2]`). Write `addr=0x00`, `wdata=0x3C`; peripheral output = 0x3C after `ncs` rises. Then write 0xFF; output = 0xFF.
- **Back-to-back**: hold `req=1` with `addr=0x01`, `wdata=0x55`. Two consecutive frames; the second `ncs` fall is exactly `CS_GAP+1` = 5 cycles after the first `ncs` rise, and the frames are bit-identical.
- **Latch and ignore**: change `wdata` 0x0F→0xF0 two cycles after accept, and pulse `req` mid-frame. The frame carries 0x0F, the mid-frame `req` produces no extra frame, and `busy` stays 1 throughout.
- **Reset mid-frame**: assert `rst_n=0` after the 7th `sclk` rise. In the same cycle, `ncs=1`, `sclk=0`, `copi=0`, `ready=1`. The peripheral register is unchanged. A following write of `0x02`/`0x81` completes correctly.
- **Minimum divider**: with `CLK_DIV=2`, `CS_GAP=1`, write `0x00`/`0xC3`. `ncs` is low for 66 cycles, the loopback peripheral receives 0xC3, and each `sclk` level lasts exactly 2 cycles.

Source files
------------

// File: rtl/spi_controller.sv
// Write-only SPI initiator (mode 0, MSB first) emitting 16-bit {1, addr, data}
// register-write frames for the on-chip SPI peripheral.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic       ready,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
  output logic       copi
);

  localparam int unsigned PH_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned SH_W   = 15;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOW  = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [3:0]      bit_q, bit_d;
  logic [SH_W-1:0] sh_q, sh_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sclk_q, sclk_d;
  logic            ncs_q, ncs_d;
  logic            copi_q, copi_d;
  logic            div_end, gap_end;

  assign div_end = (ph_q == PH_W'(CLK_DIV - 1));
  assign gap_end = (ph_q == PH_W'(CS_GAP - 1));

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
    end
  end

  // Next-state and output decode; the shift register holds the bits after the one on copi
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + PH_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    copi_d  = copi_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (req) begin
          state_d = S_LOW;
          sh_d    = {addr, wdata};
          bit_d   = 4'd15;
          ncs_d   = 1'b0;
          copi_d  = 1'b1;
        end
      end
      S_LOW: begin
        if (div_end) begin
          state_d = S_HIGH;
          sclk_d  = 1'b1;
          ph_d    = '0;
        end
      end
      S_HIGH: begin
        if (div_end) begin
          ph_d   = '0;
          sclk_d = 1'b0;
          if (bit_q != 4'd0) begin
            state_d = S_LOW;
            bit_d   = bit_q - 4'd1;
            copi_d  = sh_q[SH_W-1];
            sh_d    = {sh_q[SH_W-2:0], 1'b0};
          end else begin
            state_d = S_HOLD;
            copi_d  = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (div_end) begin
          state_d = S_GAP;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          ph_d    = '0;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
        sclk_d  = 1'b0;
        ncs_d   = 1'b1;
        copi_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign ncs   = ncs_q;
  assign copi  = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: default divider plus a minimum-divider instance,
// each with a frame monitor and a behavioural register-file receiver.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req   [2];
  logic [6:0] addr  [2];
  logic [7:0] wdata [2];
  logic       ready [2];
  logic       busy  [2];
  logic       done  [2];
  logic       sclk  [2];
  logic       ncs   [2];
  logic       copi  [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q [2][$];
  logic [7:0]  pregs [2][128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  spi_controller #(.CLK_DIV(4), .CS_GAP(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .ready(ready[0]), .addr(addr[0]),
    .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .sclk(sclk[0]),
    .ncs(ncs[0]), .copi(copi[0])
  );

  spi_controller #(.CLK_DIV(2), .CS_GAP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .ready(ready[1]), .addr(addr[1]),
    .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .sclk(sclk[1]),
    .ncs(ncs[1]), .copi(copi[1])
  );

  // Frame monitor and receiver: captures copi on sclk rises while ncs is low
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int DIV = (g == 0) ? 4 : 2;
    bit          inf = 1'b0;
    int          bits, low, lvl;
    logic [15:0] sh, ef;
    bit          bad_lvl, bad_copi;
    logic        sclk_p = 1'b0, ncs_p = 1'b1, copi_p = 1'b0;

    always @(negedge clk) begin
      if (!rst_n) begin
        if (inf) check("abort_short_frame", 32'(bits < 16), 32'd1);
        inf = 1'b0;
      end else if (inf && !ncs[g]) begin
        low++;
        if (sclk[g] && !sclk_p) begin
          sh = {sh[14:0], copi[g]};
          bits++;
        end
        if (sclk[g] != sclk_p) begin
          if (lvl != DIV) bad_lvl = 1'b1;
          lvl = 1;
        end else begin
          lvl++;
        end
        if (copi[g] != copi_p && !(sclk_p && !sclk[g])) bad_copi = 1'b1;
      end else if (inf) begin
        check("rise_count", 32'(bits), 32'd16);
        check("ncs_low_time", 32'(low), 32'(33 * DIV));
        check("last_fall_to_ncs", 32'(lvl), 32'(DIV));
        check("sclk_level_len", 32'(bad_lvl), 32'd0);
        check("copi_stability", 32'(bad_copi), 32'd0);
        check("done_with_ncs", 32'(done[g]), 32'd1);
        check("frame_expected", 32'(exp_q[g].size() != 0), 32'd1);
        if (exp_q[g].size() != 0) begin
          ef = exp_q[g].pop_front();
          check("frame_bits", 32'(sh), 32'(ef));
        end
        if (bits == 16 && sh[15]) pregs[g][sh[14:8]] = sh[7:0];
        inf = 1'b0;
      end else if (ncs_p && !ncs[g]) begin
        inf = 1'b1; bits = 0; low = 1; lvl = 1; sh = '0;
        bad_lvl = 1'b0; bad_copi = 1'b0;
      end
      sclk_p = sclk[g];
      ncs_p  = ncs[g];
      copi_p = copi[g];
    end
  end

  task automatic wait_ready(input int g);
    int n = 0;
    while (!ready[g] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready[g]), 32'd1);
  endtask

  task automatic send(input int g, input logic [6:0] a, input logic [7:0] d, input bit push);
    wait_ready(g);
    req[g] = 1'b1; addr[g] = a; wdata[g] = d;
    if (push) exp_q[g].push_back({1'b1, a, d});
    @(negedge clk);
    req[g] = 1'b0;
    check("accept_ncs", 32'(ncs[g]), 32'd0);
    check("accept_busy", 32'(busy[g]), 32'd1);
    check("accept_ready", 32'(ready[g]), 32'd0);
    check("accept_copi", 32'(copi[g]), 32'd1);
  endtask

  task automatic wait_done(input int g, output int cyc);
    cyc = 0;
    while (!done[g] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done[g]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, r;
    bit busy_bad;
    logic sp;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; addr[g] = '0; wdata[g] = '0;
      for (int a = 0; a < 128; a++) pregs[g][a] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ncs", 32'(ncs[0]), 32'd1);
    check("rst_sclk", 32'(sclk[0]), 32'd0);
    check("rst_copi", 32'(copi[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_ready", 32'(ready[0]), 32'd1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single write
    send(0, 7'h00, 8'hA5, 1'b1);
    wait_done(0, n);
    check("accept_to_done", 32'(n), 32'd132);
    @(negedge clk);
    check("done_one_cycle", 32'(done[0]), 32'd0);
    k = 1;
    while (!ready[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("done_to_ready", 32'(k), 32'd4);
    check("reg0_a5", 32'(pregs[0][0]), 32'h0A5);

    // Loopback writes
    send(0, 7'h00, 8'h3C, 1'b1);
    wait_done(0, n);
    wait_ready(0);
    check("reg0_3c", 32'(pregs[0][0]), 32'h03C);
    send(0, 7'h00, 8'hFF, 1'b1);
    wait_done(0, n);
    wait_ready(0);
    check("reg0_ff", 32'(pregs[0][0]), 32'h0FF);

    // Back-to-back with req held
    req[0] = 1'b1; addr[0] = 7'h01; wdata[0] = 8'h55;
    exp_q[0].push_back(16'h8155);
    exp_q[0].push_back(16'h8155);
    @(negedge clk);
    n = 0;
    while (!ncs[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    k = 0;
    while (ncs[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    req[0] = 1'b0;
    check("b2b_gap", 32'(k), 32'd5);
    wait_done(0, n);
    wait_ready(0);
    check("reg1_55", 32'(pregs[0][1]), 32'h055);

    // Latch and ignore
    send(0, 7'h00, 8'h0F, 1'b1);
    busy_bad = 1'b0;
    n = 0;
    while (!done[0] && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) wdata[0] = 8'hF0;
      if (n == 40) req[0] = 1'b1;
      if (n == 41) req[0] = 1'b0;
      if (!busy[0]) busy_bad = 1'b1;
    end
    check("busy_through_frame", 32'(busy_bad), 32'd0);
    wait_ready(0);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ncs[0]) k++;
    end
    check("no_extra_frame", 32'(k), 32'd0);
    check("queue_drained", 32'(exp_q[0].size()), 32'd0);
    check("reg0_0f", 32'(pregs[0][0]), 32'h00F);

    // Reset mid-frame
    send(0, 7'h00, 8'h11, 1'b0);
    r = 0; n = 0; sp = sclk[0];
    while (r < 7 && n < 2000) begin
      @(negedge clk);
      n++;
      if (sclk[0] && !sp) r++;
      sp = sclk[0];
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ncs", 32'(ncs[0]), 32'd1);
    check("mid_rst_sclk", 32'(sclk[0]), 32'd0);
    check("mid_rst_copi", 32'(copi[0]), 32'd0);
    check("mid_rst_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reg0_kept", 32'(pregs[0][0]), 32'h00F);
    send(0, 7'h02, 8'h81, 1'b1);
    wait_done(0, n);
    wait_ready(0);
    check("reg2_81", 32'(pregs[0][2]), 32'h081);

    // Minimum divider instance
    send(1, 7'h00, 8'hC3, 1'b1);
    wait_done(1, n);
    check("min_div_ncs_low", 32'(n), 32'd66);
    wait_ready(1);
    check("min_div_reg0_c3", 32'(pregs[1][0]), 32'h0C3);
    check("queue0_empty", 32'(exp_q[0].size()), 32'd0);
    check("queue1_empty", 32'(exp_q[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
